// File: rtl/sum4_acc.sv
// Groups of four unsigned samples are summed; each completed sum is presented on
// data_o with a one-cycle en_o strobe for a downstream divide-by-4 stage.
module sum4_acc #(
  parameter int WIDTH = 4,
  parameter int SUM_W = WIDTH + 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             clear_i,
  output logic [SUM_W-1:0] data_o,
  output logic             en_o,
  output logic [1:0]       count_o
);

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [SUM_W-1:0] acc;
  logic             take;
  logic             last;

  // Four full-scale samples fit in SUM_W bits, so a plain widening add cannot wrap.
  function automatic logic [SUM_W-1:0] acc_add(input logic [SUM_W-1:0] a,
                                               input logic [WIDTH-1:0] d);
    return a + {{(SUM_W-WIDTH){1'b0}}, d};
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ACCUM;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    take      = 1'b0;
    last      = 1'b0;
    case (state)
      ACCUM: begin
        ready_o = 1'b1;
        take    = valid_i && !clear_i;
        last    = take && (count_o == 2'd3);
        if (last) state_nxt = EMIT;
      end
      EMIT: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc     <= '0;
      count_o <= 2'd0;
      data_o  <= '0;
      en_o    <= 1'b0;
    end else begin
      en_o <= last;
      // clear only acts in ACCUM and wins over a same-cycle handshake
      if (ready_o && clear_i) begin
        acc     <= '0;
        count_o <= 2'd0;
      end else if (last) begin
        data_o  <= acc_add(acc, data_i);
        acc     <= '0;
        count_o <= 2'd0;
      end else if (take) begin
        acc     <= acc_add(acc, data_i);
        count_o <= count_o + 2'd1;
      end
    end
  end

endmodule
